// File: rtl/vec_sum_squares_q16.sv
// -----------------------------------------------------------------------------
// vec_sum_squares_q16
// Iterative sum-of-squares unit. A signed Q8.8 vector (dx, dy[, dz]) is turned
// into |v|^2 as unsigned Q16.16 for the downstream 32->16 square-root stage.
// One shared shift-add multiplier retires BITS_PER_CYCLE multiplier bits per
// cycle. Valid/ready on both sides; one vector in flight.
//
// Build option: define VSS_3D_EN to add the dz port and sum three squares.
// Without it the block is 2D (dx^2 + dy^2).
// -----------------------------------------------------------------------------
module vec_sum_squares_q16 #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   dx,
  input  logic [WIDTH-1:0]   dy,
`ifdef VSS_3D_EN
  input  logic [WIDTH-1:0]   dz,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data
);

`ifdef VSS_3D_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int OW     = 2 * WIDTH;
  localparam int CYCLES = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W  = $clog2(CYCLES);
  localparam int IDX_W  = $clog2(N);
  localparam int SH_W   = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_mag [N];
  logic [WIDTH-1:0]   w_in_mag [N];
  logic [OW-1:0]      r_pp;
  logic [OW-1:0]      r_acc;
  logic [OW-1:0]      r_out_data;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_bitcnt;

  logic [WIDTH-1:0]          w_cur_mag;
  logic [SH_W-1:0]           w_shift;
  logic [BITS_PER_CYCLE-1:0] w_chunk;
  logic [OW-1:0]             w_term;
  logic [OW-1:0]             w_pp_next;
  logic [OW-1:0]             w_acc_next;
  logic                      w_last_bit;
  logic                      w_last_comp;

  // Two's-complement magnitude; the most negative code maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // Magnitudes of the incoming components, captured on accept.
  always_comb begin
    w_in_mag[0] = f_abs(dx);
    w_in_mag[1] = f_abs(dy);
`ifdef VSS_3D_EN
    w_in_mag[2] = f_abs(dz);
`endif
  end

  // Multiplier step: multiplicand times the next multiplier chunk, LSB first.
  // The same magnitude serves as multiplicand and multiplier (squaring).
  assign w_cur_mag   = r_mag[r_idx];
  assign w_shift     = SH_W'(r_bitcnt) * SH_W'(BITS_PER_CYCLE);
  assign w_chunk     = w_cur_mag[w_shift +: BITS_PER_CYCLE];
  assign w_term      = (OW'(w_cur_mag) * OW'(w_chunk)) << w_shift;
  assign w_pp_next   = r_pp + w_term;
  assign w_acc_next  = r_acc + w_pp_next;
  assign w_last_bit  = (r_bitcnt == CNT_W'(CYCLES - 1));
  assign w_last_comp = (r_idx == IDX_W'(N - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode: IDLE -> MUL on accept, MUL -> DONE after the last
  // component's final step, DONE -> IDLE on output handshake.
  always_comb begin
    // NOTE: default first so every path assigns, otherwise a latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid)                  w_state_next = S_MUL;
      S_MUL:  if (w_last_bit && w_last_comp) w_state_next = S_DONE;
      S_DONE: if (out_ready)                 w_state_next = S_IDLE;
      default:                               w_state_next = S_IDLE;
    endcase
  end

  // Output decode: handshakes are pure functions of state.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    out_data  = r_out_data;
  end

  // Datapath: operand capture, shift-add partial product, accumulate, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand array is a handful of flops, not a RAM, so it is
      // reset like any other register to give a clean post-reset state.
      for (int i = 0; i < N; i++) r_mag[i] <= '0;
      r_pp       <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_idx      <= '0;
      r_bitcnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) r_mag[i] <= w_in_mag[i];
            r_pp     <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_bitcnt <= '0;
          end
        end
        S_MUL: begin
          if (w_last_bit) begin
            // Product complete: fold into the accumulator in this same cycle.
            r_pp     <= '0;
            r_bitcnt <= '0;
            r_acc    <= w_acc_next;
            r_idx    <= r_idx + IDX_W'(1);
            if (w_last_comp) r_out_data <= w_acc_next;
          end else begin
            r_pp     <= w_pp_next;
            r_bitcnt <= r_bitcnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_sum_squares_q16.sv
// -----------------------------------------------------------------------------
// tb_vec_sum_squares_q16
// Self-checking bench: a cycle-level behavioural model (plain integer squares
// plus a busy flag and an accept timestamp) is compared against the DUT on
// every falling edge; directed vectors also carry literal expectations.
// -----------------------------------------------------------------------------
module tb_vec_sum_squares_q16;

  localparam int WIDTH = 16;
  localparam int BPC   = 1;
`ifdef VSS_3D_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int LAT = N * WIDTH / BPC;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dx = '0, dy = '0, dz = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;

  vec_sum_squares_q16 #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dx        (dx),
    .dy        (dy),
`ifdef VSS_3D_EN
    .dz        (dz),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum of squares of the signed components, plain integer math.
  function automatic logic [63:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    longint sx, sy, sz, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sz = longint'($signed(z));
    r  = sx * sx + sy * sy;
`ifdef VSS_3D_EN
    r  = r + sz * sz;
`endif
    return 64'(r);
  endfunction

  // Transaction-level model state.
  bit          chk_en   = 1'b0;
  bit          m_busy   = 1'b0;
  int          cycle    = 0;
  int          m_accept = 0;
  logic [63:0] m_exp    = '0;
  logic [63:0] m_last   = '0;

  // Model update: accept when idle, release after LAT edges plus handshake.
  always @(posedge clk or negedge rst_n) begin
    bit v;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_exp  = '0;
      m_last = '0;
    end else begin
      v = m_busy && ((cycle - m_accept) >= LAT);
      cycle++;
      if (v && out_ready) begin
        m_busy = 1'b0;
        m_last = m_exp;
      end else if (!m_busy && in_valid) begin
        m_busy   = 1'b1;
        m_accept = cycle;
        m_exp    = model(dx, dy, dz);
      end
    end
  end

  // Compare process: every falling edge out of reset.
  always @(negedge clk) begin
    bit ev;
    if (rst_n && chk_en) begin
      ev = m_busy && ((cycle - m_accept) >= LAT);
      check("cmp_in_ready",  64'(in_ready),  64'(!m_busy));
      check("cmp_out_valid", 64'(out_valid), 64'(ev));
      check("cmp_out_data",  64'(out_data),  ev ? m_exp : m_last);
    end
  end

  // Present one vector at a falling edge and hold it for a single rising edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    int k = 0;
    while (m_busy && k < LAT + 20) begin
      @(negedge clk);
      k++;
    end
    if (m_busy) check("send_idle_timeout", 64'(m_busy), 64'd0);
    dx = x; dy = y; dz = z;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the result, check latency and value, optionally stall,
  // then handshake. noise drives ignored in_valid pulses while busy.
  task automatic finish_vec(input string name, input logic [63:0] exp, input int hold,
                            input bit noise);
    int k = 0;
    while (!out_valid && k < LAT + 10) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        dx = 16'($urandom); dy = 16'($urandom); dz = 16'($urandom);
      end
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    check({name, "_valid"},   64'(out_valid), 64'd1);
    check({name, "_latency"}, 64'(cycle - m_accept), 64'(LAT));
    check({name, "_data"},    64'(out_data), exp);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] x, y, z;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Hand-computed pins on the model itself.
    check("model_3_4",      model(16'h0300, 16'h0400, 16'h0000), 64'h0019_0000);
    check("model_neg_1p5",  model(16'hFE80, 16'h0000, 16'h0000), 64'h0002_4000);
    check("model_max",      model(16'h8000, 16'h8000, 16'h0000), 64'h8000_0000);

    // Directed vectors with literal expectations.
    send(16'h0300, 16'h0400, 16'h0000);
    finish_vec("d_3_4", 64'h0019_0000, 0, 1'b0);
    send(16'hFE80, 16'h0000, 16'h0000);
    finish_vec("d_neg_1p5", 64'h0002_4000, 1, 1'b0);
    send(16'h8000, 16'h8000, 16'h0000);
    finish_vec("d_max", 64'h8000_0000, 0, 1'b0);
    send(16'h0000, 16'h0000, 16'h0000);
    finish_vec("d_zero", 64'h0000_0000, 0, 1'b0);
    send(16'h0100, 16'h0200, 16'h0200);
`ifdef VSS_3D_EN
    finish_vec("d_1_2_2", 64'h0009_0000, 0, 1'b0);
`else
    finish_vec("d_1_2_2", 64'h0005_0000, 0, 1'b0);
`endif

    // Back-pressure: result held 10 cycles while other vectors are offered.
    send(16'h0300, 16'h0400, 16'h0000);
    begin
      int k = 0;
      while (!out_valid && k < LAT + 10) begin
        @(negedge clk);
        k++;
      end
    end
    check("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      dx = 16'($urandom); dy = 16'($urandom); dz = 16'($urandom);
      @(negedge clk);
      check("bp_hold_data",  64'(out_data), 64'h0019_0000);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    // Release with a new vector already offered: taken one edge after handshake.
    dx = 16'h0100; dy = 16'h0100; dz = 16'h0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_hs_out_valid", 64'(out_valid), 64'd0);
    check("bp_hs_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept_in_ready", 64'(in_ready), 64'd0);
    finish_vec("bp_next", 64'h0002_0000, 0, 1'b0);

    // Reset in the middle of MUL discards the vector.
    send(16'h1234, 16'h0567, 16'h0000);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    check("mid_rst_out_data",  64'(out_data),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'hFF00, 16'h0200, 16'h0000);
    finish_vec("post_rst", 64'h0005_0000, 0, 1'b0);

    // Randomized vectors against the model, with stalls and ignored pulses.
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
      if ($urandom_range(0, 7) == 0) x = 16'h8000;
      if ($urandom_range(0, 7) == 0) y = 16'h8000;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(x, y, z);
      finish_vec("rand", model(x, y, z), int'($urandom_range(0, 3)), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
